pds_router: RTL and testbench
=============================

// Module: pds_router
// PURPOSE
// - Packet distribution router: one input packet stream, NPORTS output channels.
// - Supports single-destination (port number) and multicast (port bitmask) packets.
// - First beat of each packet is the header; it selects the destinations.
// - Sits between the packet source and the per-port sinks of the PDS.
// - Parametrised successor of the 4-port single/multicast distributor: any port
//   count, any data width, registered output, lockstep multicast, error drop.
// PARAMETERS
// - NPORTS  default 4   number of output channels, 2..DW-1
// - DW      default 8   data width of in_data/out_data
// - PW      default $clog2(NPORTS)   port-number field width (derived)
// - CNTW    default 16  width of each statistics counter (PDS_STATS_EN only)
// PORTS
// - clk       in   1            single clock, rising edge
// - rst       in   1            asynchronous reset, active-low
// - in_valid  in   1            input beat valid
// - in_ready  out  1            input beat accepted when in_valid&in_ready
// - in_data   in   DW           input beat data
// - in_sop    in   1            first beat (header) of packet
// - in_eop    in   1            last beat of packet
// - out_valid out  NPORTS       per-port beat valid
// - out_ready in   NPORTS       per-port sink ready
// - out_data  out  DW           shared output data, all ports
// - out_sop   out  1            shared start-of-packet flag
// - out_eop   out  1            shared end-of-packet flag
// - busy      out  1            high while state!=IDLE or output register full
// - drop      out  1            one-cycle pulse when a packet/beat is discarded
// BEHAVIOUR
// - Header decode: in_data[DW-1]=0 -> single, dst = 1<<in_data[PW-1:0].
//   in_data[DW-1]=1 -> multicast, dst = in_data[NPORTS-1:0].
// - Illegal header: single with port>=NPORTS, or multicast with mask==0.
// - FSM states: IDLE, FWD, DROP. Reset state IDLE.
// - IDLE, beat with sop, legal header -> latch dst, forward beat. Go to FWD if !eop, else stay.
// - IDLE, beat with sop, illegal header -> drop pulse. Go to DROP if !eop, else stay.
// - IDLE, beat without sop -> consumed, discarded, drop pulse, stay IDLE.
// - FWD: each beat is forwarded to the latched dst. in_sop is ignored. Beat with eop -> IDLE.
// - DROP: in_ready=1, beats discarded, no further pulses. Beat with eop -> IDLE.
// - Output register: one beat deep, holds data/sop/eop/dst. Latency is 1 cycle from accept to out_valid.
// - out_valid[i] = full & dst[i]. A beat retires only when all its dst ports are ready
//   in the same cycle (lockstep multicast). No partial delivery, no duplication.
// - in_ready (IDLE/FWD) = !full | retire. This gives full throughput with ready held high.
// - Simultaneous retire and accept: the register reloads and out_valid stays high.
// - Non-dst ports never see out_valid. out_data is don't-care when out_valid==0.
// - Reset (async assert, any time, mid-packet included):
//   - state=IDLE, output register empty.
//   - out_valid=0, out_data=0, out_sop=0, out_eop=0, busy=0, drop=0.
//   - Counters are cleared.
//   - After reset the partial packet is lost; the next non-sop beats are dropped per the IDLE rule.
// - drop is asserted in the cycle after the discarding handshake, registered.
// CONFIGURATION
// - PDS_STATS_EN defined:
//   - Adds output pkt_cnt [NPORTS*CNTW] (per-port delivered-packet count, increments on retire of an eop beat per dst port).
//   - Adds output drop_cnt [CNTW] (increments with each drop pulse).
//   - Both counters saturate at all-ones. Both reset to 0.
// - PDS_STATS_EN undefined: the ports and counters are absent. Datapath behaviour is identical.
// TESTING
// - Single: header 8'h02, 3 beats, all ready -> only out_valid[2].
//   - out_valid high on cycles +1..+3, sop on beat 1, eop on beat 3.
// - Multicast: header 8'h85 (ports 0,2), out_ready[2]=0 for 4 cycles -> beat held on ports 0 and 2.
//   - in_ready=0 while held. Beat retires on the cycle out_ready[2] rises, exactly once per port.
// - Illegal: header 8'h06 (port 6 >= 4), 4 beats -> in_ready=1 throughout, out_valid=0, one drop pulse.
//   - Following legal packet 8'h01 is delivered to port 1.
// - Back-to-back: single-beat packets 8'h00, 8'h01, 8'h03, all ready -> one delivery per cycle.
//   - Delivered on port 0, then 1, then 3. No bubbles.
// - Reset mid-packet: assert rst after beat 2 of 5 -> all outputs 0 immediately.
//   - After release, the 3 trailing non-sop beats are dropped: 3 drop pulses.
// - PDS_STATS_EN: send 3 packets to 85, 1 illegal -> pkt_cnt[0]=3, pkt_cnt[2]=3, drop_cnt=1.
//   - With CNTW=2, a 4th packet to 85 leaves pkt_cnt[0] saturated at 3.

Source files
------------

// File: rtl/pds_router.sv
// rtl/pds_router.sv - packet distribution router, one input stream to NPORTS lockstep-multicast outputs
// Optional per-port delivery and drop statistics enabled by PDS_STATS_EN.
module pds_router #(
  parameter int NPORTS = 4,
  parameter int DW     = 8,
  parameter int PW     = $clog2(NPORTS)
`ifdef PDS_STATS_EN
  , parameter int CNTW = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [NPORTS-1:0] out_valid,
  input  logic [NPORTS-1:0] out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic              drop
`ifdef PDS_STATS_EN
  , output logic [NPORTS*CNTW-1:0] pkt_cnt,
  output logic [CNTW-1:0]          drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  localparam logic [DW-2:0]     PORT_LIM = (DW-1)'(NPORTS);
  localparam logic [NPORTS-1:0] ONE_HOT0 = NPORTS'(1);

  state_t            state, state_nx;
  logic              full;
  logic [NPORTS-1:0] held_dst;
  logic [NPORTS-1:0] pkt_dst;
  logic [NPORTS-1:0] hdr_dst;
  logic              hdr_legal;
  logic              space;
  logic              retire;
  logic              fwd_beat;
  logic              drop_ev;

  // The whole non-type field is range-checked, so e.g. port 6 on a 4-port router is illegal.
  always_comb begin
    hdr_dst   = '0;
    hdr_legal = 1'b0;
    if (in_data[DW-1]) begin
      hdr_dst   = in_data[NPORTS-1:0];
      hdr_legal = |in_data[NPORTS-1:0];
    end else if (in_data[DW-2:0] < PORT_LIM) begin
      hdr_dst   = ONE_HOT0 << in_data[PW-1:0];
      hdr_legal = 1'b1;
    end
  end

  assign retire    = full && ((held_dst & ~out_ready) == '0);
  assign space     = !full || retire;
  assign out_valid = full ? held_dst : '0;
  assign busy      = (state != IDLE) || full;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    fwd_beat = 1'b0;
    drop_ev  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = space;
        if (in_valid && space) begin
          if (in_sop && hdr_legal) begin
            fwd_beat = 1'b1;
            if (!in_eop) state_nx = FWD;
          end else begin
            drop_ev = 1'b1;
            if (in_sop && !in_eop) state_nx = DROP;
          end
        end
      end
      FWD: begin
        in_ready = space;
        if (in_valid && space) begin
          fwd_beat = 1'b1;
          if (in_eop) state_nx = IDLE;
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_eop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      full     <= 1'b0;
      held_dst <= '0;
      pkt_dst  <= '0;
      out_data <= '0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state <= state_nx;
      drop  <= drop_ev;
      if (fwd_beat) begin
        full     <= 1'b1;
        out_data <= in_data;
        out_sop  <= (state == IDLE);
        out_eop  <= in_eop;
        held_dst <= (state == IDLE) ? hdr_dst : pkt_dst;
        if (state == IDLE) pkt_dst <= hdr_dst;
      end else if (retire) begin
        full <= 1'b0;
      end
    end
  end

`ifdef PDS_STATS_EN
  logic [CNTW-1:0] port_cnt [NPORTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPORTS; i++) port_cnt[i] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (retire && out_eop && held_dst[i] && (port_cnt[i] != '1))
          port_cnt[i] <= port_cnt[i] + 1'b1;
      end
      if (drop_ev && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_pack
    assign pkt_cnt[g*CNTW +: CNTW] = port_cnt[g];
  end
`endif

endmodule

// File: tb/tb_pds_router.sv
// tb/tb_pds_router.sv - directed vector bench for pds_router (PDS_STATS_EN section when defined)
module tb_pds_router;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       busy;
  logic       drop;
`ifdef PDS_STATS_EN
  logic [7:0] pkt_cnt;
  logic [1:0] drop_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef PDS_STATS_EN
  pds_router #(.NPORTS(4), .DW(8), .CNTW(2)) dut (
`else
  pds_router #(.NPORTS(4), .DW(8)) dut (
`endif
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .busy(busy), .drop(drop)
`ifdef PDS_STATS_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [3:0] rdy;
    logic [3:0] e_ov;
    logic       e_ir;
    logic [7:0] e_d;
    logic       e_sop;
    logic       e_eop;
    logic       e_busy;
    logic       e_drop;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic v, logic [7:0] d, logic sop, logic eop, logic [3:0] rdy,
                              logic [3:0] e_ov, logic e_ir, logic [7:0] e_d, logic e_sop,
                              logic e_eop, logic e_busy, logic e_drop);
    vec_t t;
    t.v = v; t.d = d; t.sop = sop; t.eop = eop; t.rdy = rdy;
    t.e_ov = e_ov; t.e_ir = e_ir; t.e_d = e_d; t.e_sop = e_sop;
    t.e_eop = e_eop; t.e_busy = e_busy; t.e_drop = e_drop;
    vq.push_back(t);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] d, logic sop, logic eop, logic [3:0] rdy);
    @(negedge clk);
    in_valid = v; in_data = d; in_sop = sop; in_eop = eop; out_ready = rdy;
    #1;
  endtask

  int pulses;
  int ov_seen;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 4'hF;

    // single to port 2, 3 beats
    add(1, 8'h02, 1, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    add(1, 8'hAA, 0, 0, 4'hF, 4'h4, 1, 8'h02, 1, 0, 1, 0);
    add(1, 8'hBB, 0, 1, 4'hF, 4'h4, 1, 8'hAA, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h4, 1, 8'hBB, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    // multicast to ports 0,2 with port 2 stalled for 4 cycles
    add(1, 8'h85, 1, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 8'h11, 0, 1, 4'hB, 4'h5, 0, 8'h85, 1, 0, 1, 0);
    add(1, 8'h11, 0, 1, 4'hF, 4'h5, 1, 8'h85, 1, 0, 1, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h5, 1, 8'h11, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    // illegal port 6, 4 beats, then legal packet to port 1
    add(1, 8'h06, 1, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    add(1, 8'h01, 0, 0, 4'h0, 4'h0, 1, 8'h00, 0, 0, 1, 1);
    add(1, 8'h02, 0, 0, 4'h0, 4'h0, 1, 8'h00, 0, 0, 1, 0);
    add(1, 8'h03, 0, 1, 4'h0, 4'h0, 1, 8'h00, 0, 0, 1, 0);
    add(1, 8'h01, 1, 1, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h2, 1, 8'h01, 1, 1, 1, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    // back-to-back single-beat packets to ports 0,1,3
    add(1, 8'h00, 1, 1, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    add(1, 8'h01, 1, 1, 4'hF, 4'h1, 1, 8'h00, 1, 1, 1, 0);
    add(1, 8'h03, 1, 1, 4'hF, 4'h2, 1, 8'h01, 1, 1, 1, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h8, 1, 8'h03, 1, 1, 1, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    // stray beat, empty mask, port 4, mask from upper bits only
    add(1, 8'h55, 0, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    add(1, 8'h80, 1, 1, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 1);
    add(1, 8'h04, 1, 1, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 1);
    add(1, 8'h90, 1, 1, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    // broadcast to all four ports
    add(1, 8'h8F, 1, 1, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'hF, 1, 8'h8F, 1, 1, 1, 0);
    add(0, 8'h00, 0, 0, 4'hF, 4'h0, 1, 8'h00, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset sop/eop", {30'd0, out_sop, out_eop}, 0);
    chk("reset busy/drop", {30'd0, busy, drop}, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vq[k]) begin
      drive(vq[k].v, vq[k].d, vq[k].sop, vq[k].eop, vq[k].rdy);
      chk($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(vq[k].e_ov));
      chk($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(vq[k].e_ir));
      chk($sformatf("vec%0d busy", k), 32'(busy), 32'(vq[k].e_busy));
      chk($sformatf("vec%0d drop", k), 32'(drop), 32'(vq[k].e_drop));
      if (vq[k].e_ov != 4'h0) begin
        chk($sformatf("vec%0d out_data", k), 32'(out_data), 32'(vq[k].e_d));
        chk($sformatf("vec%0d sop/eop", k), {30'd0, out_sop, out_eop}, {30'd0, vq[k].e_sop, vq[k].e_eop});
      end
    end

    // reset after beat 2 of a 5-beat packet to port 1
    drive(1, 8'h01, 1, 0, 4'hF);
    drive(1, 8'h22, 0, 0, 4'hF);
    chk("mid out_valid b1", 32'(out_valid), 32'h2);
    drive(0, 8'h00, 0, 0, 4'hF);
    chk("mid out_valid b2", 32'(out_valid), 32'h2);
    chk("mid out_data b2", 32'(out_data), 32'h22);
    rst = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 0);
    chk("async out_data", 32'(out_data), 0);
    chk("async sop/eop/busy/drop", {28'd0, out_sop, out_eop, busy, drop}, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    ov_seen = 0;
    drive(1, 8'h33, 0, 0, 4'hF);
    pulses += int'(drop); ov_seen |= int'(out_valid);
    drive(1, 8'h44, 0, 0, 4'hF);
    pulses += int'(drop); ov_seen |= int'(out_valid);
    chk("trail drop 1", 32'(drop), 1);
    drive(1, 8'h55, 0, 1, 4'hF);
    pulses += int'(drop); ov_seen |= int'(out_valid);
    drive(0, 8'h00, 0, 0, 4'hF);
    pulses += int'(drop); ov_seen |= int'(out_valid);
    drive(0, 8'h00, 0, 0, 4'hF);
    pulses += int'(drop); ov_seen |= int'(out_valid);
    chk("trail drop pulses", 32'(pulses), 3);
    chk("trail out_valid", 32'(ov_seen), 0);
    chk("trail busy", 32'(busy), 0);

`ifdef PDS_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("stats reset pkt_cnt", 32'(pkt_cnt), 0);
    chk("stats reset drop_cnt", 32'(drop_cnt), 0);
    for (int p = 0; p < 3; p++) begin
      drive(1, 8'h85, 1, 0, 4'hF);
      drive(1, 8'h33, 0, 1, 4'hF);
    end
    drive(1, 8'h04, 1, 1, 4'hF);
    repeat (3) drive(0, 8'h00, 0, 0, 4'hF);
    chk("pkt_cnt[0]", 32'(pkt_cnt[1:0]), 3);
    chk("pkt_cnt[1]", 32'(pkt_cnt[3:2]), 0);
    chk("pkt_cnt[2]", 32'(pkt_cnt[5:4]), 3);
    chk("pkt_cnt[3]", 32'(pkt_cnt[7:6]), 0);
    chk("drop_cnt", 32'(drop_cnt), 1);
    drive(1, 8'h85, 1, 0, 4'hF);
    drive(1, 8'h33, 0, 1, 4'hF);
    repeat (3) drive(0, 8'h00, 0, 0, 4'hF);
    chk("pkt_cnt[0] sat", 32'(pkt_cnt[1:0]), 3);
    chk("pkt_cnt[2] sat", 32'(pkt_cnt[5:4]), 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
